// File: rtl/mul_div_unit.sv
// Iterative HI/LO multiply/divide unit: radix-2 shift-add multiply and restoring
// divide over operand magnitudes, with sign fix-up and the architectural HI/LO registers.
module mul_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   mag_q, mag_d;
  logic [WIDTH-1:0]   raw1_q, raw1_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic [1:0]         op_q, op_d;
  logic               sa_q, sa_d, sb_q, sb_d;
  logic               dz_q, dz_d, done_q, done_d, dbz_q, dbz_d;

  logic [WIDTH-1:0]   mag1, mag2, addend, quo, rem;
  logic [WIDTH:0]     mul_sum, rem_sh, rem_diff;

  // Signed ops work on magnitudes; 0x80..0 maps onto itself, which is the correct magnitude.
  assign mag1 = (op[0] && in1[WIDTH-1]) ? -in1 : in1;
  assign mag2 = (op[0] && in2[WIDTH-1]) ? -in2 : in2;

  // acc holds {partial product, multiplier} for mul, {remainder, dividend/quotient} for div
  assign addend   = acc_q[0] ? mag_q : '0;
  assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, addend};
  assign rem_sh   = acc_q[2*WIDTH-1:WIDTH-1];
  assign rem_diff = rem_sh - {1'b0, mag_q};
  assign quo      = acc_q[WIDTH-1:0];
  assign rem      = acc_q[2*WIDTH-1:WIDTH];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    mag_d   = mag_q;
    raw1_d  = raw1_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    op_d    = op_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    dz_d    = dz_q;
    done_d  = 1'b0;
    dbz_d   = dbz_q;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (start) begin
          state_d = S_RUN;
          op_d    = op;
          raw1_d  = in1;
          sa_d    = op[0] & in1[WIDTH-1];
          sb_d    = op[0] & in2[WIDTH-1];
          dz_d    = op[1] & (in2 == '0);
          if (op[1]) begin
            acc_d = {{WIDTH{1'b0}}, mag1};
            mag_d = mag2;
          end else begin
            acc_d = {{WIDTH{1'b0}}, mag2};
            mag_d = mag1;
          end
        end else begin
          // mthi/mtlo only land when no operation starts this cycle
          if (hi_we) hi_d = wdata;
          if (lo_we) lo_d = wdata;
        end
      end
      S_RUN: begin
        cnt_d = cnt_q + 1'b1;
        if (op_q[1]) begin
          if (!rem_diff[WIDTH])
            acc_d = {rem_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
          else
            acc_d = {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
        end else begin
          acc_d = {mul_sum, acc_q[WIDTH-1:1]};
        end
        if (cnt_q == CW'(WIDTH - 1)) state_d = S_FIX;
      end
      S_FIX: begin
        state_d = S_IDLE;
        done_d  = 1'b1;
        dbz_d   = dz_q;
        if (dz_q) begin
          lo_d = '1;
          hi_d = raw1_q;
        end else if (op_q[1]) begin
          lo_d = (sa_q ^ sb_q) ? -quo : quo;
          hi_d = sa_q ? -rem : rem;
        end else if (sa_q ^ sb_q) begin
          {hi_d, lo_d} = -acc_q;
        end else begin
          {hi_d, lo_d} = acc_q;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      mag_q   <= '0;
      raw1_q  <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      op_q    <= '0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      dz_q    <= 1'b0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      mag_q   <= mag_d;
      raw1_q  <= raw1_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      op_q    <= op_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      dz_q    <= dz_d;
      done_q  <= done_d;
      dbz_q   <= dbz_d;
    end
  end

  assign busy        = (state_q != S_IDLE);
  assign done        = done_q;
  assign div_by_zero = dbz_q;
  assign hi          = hi_q;
  assign lo          = lo_q;
endmodule

// File: tb/tb_mul_div_unit.sv
// Directed bench for mul_div_unit: table of operations with hand-computed HI/LO,
// plus sequences for busy-time inputs, mthi/mtlo, and reset mid-operation.
module tb_mul_div_unit;
  logic        clk = 1'b0;
  logic        reset, start, hi_we, lo_we;
  logic [1:0]  op;
  logic [31:0] in1, in2, wdata;
  logic        busy, done, div_by_zero;
  logic [31:0] hi, lo;

  int checks = 0;
  int errors = 0;

  mul_div_unit #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .in1(in1), .in2(in2),
    .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata), .busy(busy), .done(done),
    .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a, b, ehi, elo;
    logic        edz;
  } vec_t;

  vec_t vt[12];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Issue one operation and check latency, busy width, HI/LO hold and result.
  // b2b: start in the current (done) cycle. dk: cycle to inject ignored inputs (-1 = none).
  task automatic run_vec(input vec_t v, input string nm, input bit b2b, input int dk);
    int k, b;
    logic [31:0] hi0;
    if (!b2b) begin
      @(negedge clk);
      chk({nm, " idle done"}, done, 1'b0);
    end
    hi0   = hi;
    op    = v.op;
    in1   = v.a;
    in2   = v.b;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    in1   = $urandom;
    in2   = $urandom;
    chk({nm, " busy0"}, busy, 1'b1);
    chk({nm, " done0"}, done, 1'b0);
    k = 0;
    b = 0;
    while (done !== 1'b1 && k < 100) begin
      if (busy) b++;
      if (k == 31) chk({nm, " hold"}, hi, hi0);
      if (k == dk) begin
        start = 1'b1; op = 2'b10; in1 = 32'd1; in2 = 32'd1;
        hi_we = 1'b1; lo_we = 1'b1; wdata = 32'hDEAD;
      end
      @(negedge clk);
      k++;
      start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
    end
    chk({nm, " latency"}, k, 33);
    chk({nm, " busycyc"}, b, 33);
    chk({nm, " busy_at_done"}, busy, 1'b0);
    chk({nm, " hi"}, hi, v.ehi);
    chk({nm, " lo"}, lo, v.elo);
    chk({nm, " dbz"}, div_by_zero, v.edz);
  endtask

  initial begin
    int  k;
    bit  seen;
    logic [31:0] hsave;

    vt[0]  = '{2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0};
    vt[1]  = '{2'b01, 32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0};
    vt[2]  = '{2'b01, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0};
    vt[3]  = '{2'b11, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
    vt[4]  = '{2'b11, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0};
    vt[5]  = '{2'b10, 32'd100,      32'd0,        32'h00000064, 32'hFFFFFFFF, 1'b1};
    vt[6]  = '{2'b10, 32'd100,      32'd7,        32'd2,        32'd14,       1'b0};
    vt[7]  = '{2'b11, 32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, 1'b0};
    vt[8]  = '{2'b01, 32'd0,        32'd12345,    32'd0,        32'd0,        1'b0};
    vt[9]  = '{2'b00, 32'h12345678, 32'h00000010, 32'h00000001, 32'h23456780, 1'b0};
    vt[10] = '{2'b11, 32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB, 32'hFFFFFFFF, 1'b1};
    vt[11] = '{2'b10, 32'hFFFFFFFF, 32'd1,        32'd0,        32'hFFFFFFFF, 1'b0};

    reset = 1'b0; start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
    op = 2'b00; in1 = '0; in2 = '0; wdata = '0;
    repeat (3) @(negedge clk);
    chk("rst busy", busy, 1'b0);
    chk("rst done", done, 1'b0);
    chk("rst dbz", div_by_zero, 1'b0);
    chk("rst hi", hi, 32'h0);
    chk("rst lo", lo, 32'h0);
    reset = 1'b1;

    for (int i = 0; i < 12; i++)
      run_vec(vt[i], $sformatf("v%0d", i), (i % 2) == 1, (i == 9) ? 5 : -1);

    // mthi / mtlo in idle
    @(negedge clk);
    hsave = hi;
    lo_we = 1'b1; wdata = 32'h1234;
    @(negedge clk);
    lo_we = 1'b0;
    chk("mtlo lo", lo, 32'h1234);
    chk("mtlo hi", hi, hsave);
    hi_we = 1'b1; wdata = 32'hABCD;
    @(negedge clk);
    hi_we = 1'b0;
    chk("mthi hi", hi, 32'hABCD);

    // start wins over a same-cycle mtlo
    start = 1'b1; op = 2'b00; in1 = 32'd2; in2 = 32'd3; lo_we = 1'b1; wdata = 32'h5555;
    @(negedge clk);
    start = 1'b0; lo_we = 1'b0;
    chk("start+mtlo lo", lo, 32'h1234);
    chk("start+mtlo busy", busy, 1'b1);
    k = 0;
    while (done !== 1'b1 && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk("start+mtlo latency", k, 33);
    chk("start+mtlo res lo", lo, 32'd6);
    chk("start+mtlo res hi", hi, 32'd0);

    // reset mid-operation
    @(negedge clk);
    start = 1'b1; op = 2'b01; in1 = 32'hFFFFFFFD; in2 = 32'd5;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    chk("midrst busy", busy, 1'b0);
    chk("midrst hi", hi, 32'h0);
    chk("midrst lo", lo, 32'h0);
    seen = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (done) seen = 1'b1;
      @(negedge clk);
    end
    chk("midrst no done", seen, 1'b0);
    chk("midrst hi held", hi, 32'h0);

    run_vec(vt[1], "post-rst", 1'b0, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
